mc_mem_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory port between two requesters.

---
 rtl/mc_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mc_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_mem_arbiter.sv
// mc_mem_arbiter: shares one unified instruction/data memory port between the
// multicycle core (port 0) and a loader/DMA engine (port 1). Accesses are
// serialised through an IDLE/BUSY/DONE FSM with MEM_LAT wait cycles each.
// Build option: define MC_ARB_RR_EN for round-robin tie-breaking; otherwise
// port 0 has fixed priority.
module mc_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,
    output logic          busy,
    output logic          gnt_id
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          acc_we_q, acc_we_d;   // current access is a write
    logic          mem_we_q, mem_we_d;   // write strobe, first BUSY cycle only
    logic          gnt_q, gnt_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DW-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic          winner;

`ifdef MC_ARB_RR_EN
    logic rr_q, rr_d;

    // Round-robin: on a tie the port that did not win last time is chosen
    always_comb begin
        winner = req1;
        if (req0 && req1) winner = ~rr_q;
    end
`else
    // Fixed priority: the core wins whenever it is requesting
    always_comb begin
        winner = ~req0;
    end
`endif

    // Next-state and output logic for the access FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        wd_d     = wd_q;
        acc_we_d = acc_we_q;
        mem_we_d = 1'b0;
        gnt_d    = gnt_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rd0_d    = rd0_q;
        rd1_d    = rd1_q;
`ifdef MC_ARB_RR_EN
        rr_d     = rr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    adr_d    = winner ? addr1  : addr0;
                    wd_d     = winner ? wdata1 : wdata0;
                    acc_we_d = winner ? we1    : we0;
                    mem_we_d = winner ? we1    : we0;
                    gnt_d    = winner;
                    cnt_d    = 4'(MEM_LAT);
                    state_d  = S_BUSY;
`ifdef MC_ARB_RR_EN
                    rr_d     = winner;
`endif
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Last BUSY cycle: memory data is valid now
                    if (!acc_we_q) begin
                        if (gnt_q) rd1_d = mem_rd;
                        else       rd0_d = mem_rd;
                    end
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-high reset; drops any in-flight access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            adr_q    <= '0;
            wd_q     <= '0;
            acc_we_q <= 1'b0;
            mem_we_q <= 1'b0;
            gnt_q    <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rd0_q    <= '0;
            rd1_q    <= '0;
`ifdef MC_ARB_RR_EN
            rr_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            wd_q     <= wd_d;
            acc_we_q <= acc_we_d;
            mem_we_q <= mem_we_d;
            gnt_q    <= gnt_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rd0_q    <= rd0_d;
            rd1_q    <= rd1_d;
`ifdef MC_ARB_RR_EN
            rr_q     <= rr_d;
`endif
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign rdata0  = rd0_q;
    assign rdata1  = rd1_q;
    assign mem_adr = adr_q;
    assign mem_wd  = wd_q;
    assign mem_we  = mem_we_q;
    assign busy    = (state_q != S_IDLE);
    assign gnt_id  = gnt_q;

endmodule

// File: tb/tb_mc_mem_arbiter.sv
// Testbench for mc_mem_arbiter: three instances with MEM_LAT = 1, 0 and 15.
// Honours MC_ARB_RR_EN for tie-breaking expectations.
module tb_mc_mem_arbiter;

    logic clk;
    logic reset;

    logic [2:0]       req0_v, we0_v, req1_v, we1_v;
    logic [2:0][31:0] addr0_a, wdata0_a, addr1_a, wdata1_a;
    logic [2:0]       ack0_v, ack1_v, mem_we_v, busy_v, gnt_v;
    logic [2:0][31:0] rdata0_a, rdata1_a, mem_adr_a, mem_wd_a;
    logic [31:0]      mem_rd;

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        mc_mem_arbiter #(
            .AW(32), .DW(32),
            .MEM_LAT((g == 0) ? 1 : ((g == 1) ? 0 : 15))
        ) u_dut (
            .clk    (clk),
            .reset  (reset),
            .req0   (req0_v[g]),
            .we0    (we0_v[g]),
            .addr0  (addr0_a[g]),
            .wdata0 (wdata0_a[g]),
            .ack0   (ack0_v[g]),
            .rdata0 (rdata0_a[g]),
            .req1   (req1_v[g]),
            .we1    (we1_v[g]),
            .addr1  (addr1_a[g]),
            .wdata1 (wdata1_a[g]),
            .ack1   (ack1_v[g]),
            .rdata1 (rdata1_a[g]),
            .mem_adr(mem_adr_a[g]),
            .mem_wd (mem_wd_a[g]),
            .mem_we (mem_we_v[g]),
            .mem_rd (mem_rd),
            .busy   (busy_v[g]),
            .gnt_id (gnt_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memrd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_v = '0; req1_v = '0; we0_v = '0; we1_v = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One lone access on instance d; called at a negedge with the DUT idle.
    task automatic access(input int d, input int lat, input bit port, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] memrd, input bit vary,
                          input logic [31:0] exp_rd);
        mem_rd = memrd;
        if (!port) begin
            req0_v[d] = 1'b1; we0_v[d] = we; addr0_a[d] = addr; wdata0_a[d] = wdata;
        end else begin
            req1_v[d] = 1'b1; we1_v[d] = we; addr1_a[d] = addr; wdata1_a[d] = wdata;
        end
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            chk("busy",   32'(busy_v[d]),   32'(k <= lat + 2));
            chk("mem_we", 32'(mem_we_v[d]), 32'(we && (k == 1)));
            chk("ack0",   32'(ack0_v[d]),   32'((k == lat + 2) && !port));
            chk("ack1",   32'(ack1_v[d]),   32'((k == lat + 2) && port));
            if (k == 1) begin
                chk("mem_adr", mem_adr_a[d], addr);
                chk("mem_wd",  mem_wd_a[d],  wdata);
                chk("gnt_id",  32'(gnt_v[d]), 32'(port));
            end
            if (k == lat + 2) begin
                chk("rdata", port ? rdata1_a[d] : rdata0_a[d], exp_rd);
                req0_v[d] = 1'b0;
                req1_v[d] = 1'b0;
            end
            if (vary) mem_rd = memrd + 32'(k);
        end
    endtask

    int n0, n1, t0, t1, idx, n_exp;
    int exp_t[4];
    bit exp_p[4];

    initial begin
        reset = 1'b1;
        req0_v = '0; req1_v = '0; we0_v = '0; we1_v = '0;
        addr0_a = '0; addr1_a = '0; wdata0_a = '0; wdata1_a = '0;
        mem_rd = '0;

        vt[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'hAAAA_5555, 32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D};
        vt[3] = '{1'b0, 1'b1, 32'h0000_0080, 32'h0BAD_F00D, 32'h1111_1111, 32'hDEAD_BEEF};
        vt[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vt[5] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0,         32'h2222_2222, 32'hCAFE_F00D};

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_ack0",   32'(ack0_v[0]),   32'd0);
        chk("rst_ack1",   32'(ack1_v[0]),   32'd0);
        chk("rst_busy",   32'(busy_v[0]),   32'd0);
        chk("rst_gnt",    32'(gnt_v[0]),    32'd0);
        chk("rst_mem_we", 32'(mem_we_v[0]), 32'd0);
        chk("rst_adr",    mem_adr_a[0],     32'd0);
        chk("rst_wd",     mem_wd_a[0],      32'd0);
        chk("rst_rd0",    rdata0_a[0],      32'd0);
        chk("rst_rd1",    rdata1_a[0],      32'd0);

        // Lone accesses, MEM_LAT=1
        for (int i = 0; i < 6; i++) begin
            access(0, 1, vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata,
                   vt[i].memrd, 1'b0, vt[i].exp_rd);
        end

        // Simultaneous requests from a fresh reset
        do_reset();
        mem_rd = 32'h0000_0055;
        we0_v[0] = 1'b0; addr0_a[0] = 32'h100;
        we1_v[0] = 1'b0; addr1_a[0] = 32'h200;
        req0_v[0] = 1'b1; req1_v[0] = 1'b1;
        n0 = 0; n1 = 0; t0 = 0; t1 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ack0_v[0] && ack1_v[0]) chk("tie_both_ack", 32'd1, 32'd0);
            if (ack0_v[0]) begin
                n0++; t0 = k;
                chk("tie_gnt0", 32'(gnt_v[0]), 32'd0);
                req0_v[0] = 1'b0;
            end
            if (ack1_v[0]) begin
                n1++; t1 = k;
                chk("tie_gnt1", 32'(gnt_v[0]), 32'd1);
                req1_v[0] = 1'b0;
            end
        end
        chk("tie_n0", 32'(n0), 32'd1);
        chk("tie_n1", 32'(n1), 32'd1);
`ifdef MC_ARB_RR_EN
        chk("tie_t1", 32'(t1), 32'd3);
        chk("tie_t0", 32'(t0), 32'd7);
`else
        chk("tie_t0", 32'(t0), 32'd3);
        chk("tie_t1", 32'(t1), 32'd7);
`endif

        // Continuously held requests
`ifdef MC_ARB_RR_EN
        n_exp = 4;
        exp_t = '{3, 7, 11, 15};
        exp_p = '{1'b1, 1'b0, 1'b1, 1'b0};
        req1_v[0] = 1'b1;
`else
        n_exp = 3;
        exp_t = '{3, 7, 11, 0};
        exp_p = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        req0_v[0] = 1'b1;
        idx = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (ack0_v[0] || ack1_v[0]) begin
                if (idx < n_exp) begin
                    chk("hold_t",    32'(k),         32'(exp_t[idx]));
                    chk("hold_port", 32'(ack1_v[0]), 32'(exp_p[idx]));
                    chk("hold_gnt",  32'(gnt_v[0]),  32'(exp_p[idx]));
                end
                idx++;
                if (idx >= n_exp) begin
                    req0_v[0] = 1'b0;
                    req1_v[0] = 1'b0;
                end
            end
        end
        chk("hold_count", 32'(idx), 32'(n_exp));

        // Latency extremes; mem_rd changes every cycle
        access(1, 0,  1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_1000, 1'b1, 32'h0000_1001);
        access(2, 15, 1'b0, 1'b0, 32'h0000_0024, 32'h0, 32'h0000_2000, 1'b1, 32'h0000_2010);
        access(2, 15, 1'b1, 1'b0, 32'h0000_0028, 32'h0, 32'h0000_3000, 1'b1, 32'h0000_3010);

        // Reset during BUSY of a port-0 read
        mem_rd = 32'h0000_0099;
        we0_v[0] = 1'b0; addr0_a[0] = 32'h30; req0_v[0] = 1'b1;
        @(negedge clk);
        chk("mid_busy", 32'(busy_v[0]), 32'd1);
        reset = 1'b1;
        req0_v[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", 32'(busy_v[0]),   32'd0);
        chk("mid_rst_ack0", 32'(ack0_v[0]),   32'd0);
        chk("mid_rst_gnt",  32'(gnt_v[0]),    32'd0);
        chk("mid_rst_adr",  mem_adr_a[0],     32'd0);
        chk("mid_rst_rd0",  rdata0_a[0],      32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_no_ack0", 32'(ack0_v[0]), 32'd0);
            chk("mid_idle",    32'(busy_v[0]), 32'd0);
        end
        access(0, 1, 1'b0, 1'b0, 32'h0000_0030, 32'h0, 32'h7777_7777, 1'b0, 32'h7777_7777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
